// File: rtl/spi_flash_cmd_master_if.sv
// -----------------------------------------------------------------------------
// spi_flash_cmd_master_if
// Purpose : command/response handshake between a system-side command source
//           (master) and the SPI flash command engine (slave).
// Signals : cmd_valid/cmd_ready  - request handshake, accept = valid & ready
//           cmd_op[1:0]          - 00 read, 01 write, 10 flash reset, 11 status
//           cmd_addr[15:0]       - flash address
//           cmd_wdata[7:0]       - write data byte
//           rsp_valid            - 1-clk pulse per completed command
//           rsp_rdata[7:0]       - captured read/status byte, held until next rsp
//           busy                 - engine is working on a frame (~cmd_ready)
// -----------------------------------------------------------------------------
interface spi_flash_cmd_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        busy;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, busy
  );
endinterface

// File: rtl/spi_flash_cmd_master.sv
// -----------------------------------------------------------------------------
// spi_flash_cmd_master
// Purpose : SPI mode-0 initiator turning parallel flash commands into 32-bit
//           frames {opcode, addr, data}, MSB first, and returning one response
//           per accepted command with the last 8 sampled SDI bits.
// Params  : CLK_DIV - SCK half-period in clk cycles (>=1)
//           GAP_CYC - minimum clk cycles nSS stays high between frames (>=1)
// Ports   : clk     - system clock, rising edge
//           bi_rst  - synchronous active-high reset
//           cmd_if  - command/response handshake (slave side)
//           SCK     - serial clock, idles low
//           nSS     - slave select, active low
//           SDO     - serial data out, MSB first
//           SDI     - serial data in, sampled on SCK rising edges
// -----------------------------------------------------------------------------
module spi_flash_cmd_master #(
  parameter int CLK_DIV = 2,
  parameter int GAP_CYC = 4
) (
  input  logic                         clk,
  input  logic                         bi_rst,
  spi_flash_cmd_master_if.slave        cmd_if,
  output logic                         SCK,
  output logic                         nSS,
  output logic                         SDO,
  input  logic                         SDI
);

  localparam int CNT_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_TRAIL = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       bit_cnt_q, bit_cnt_d;
  logic [31:0]      frame_q, frame_d;
  logic [7:0]       rx_q, rx_d;
  logic [1:0]       op_q, op_d;
  logic             sck_q, sck_d;
  logic             nss_q, nss_d;
  logic             sdo_q, sdo_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_rdata_q, rsp_rdata_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             busy_q, busy_d;
  logic [31:0]      new_frame_s;

  // Assemble the serial frame; reset/status carry no address, only write carries data.
  function automatic logic [31:0] build_frame(input logic [1:0] op,
                                              input logic [15:0] addr,
                                              input logic [7:0] wdata);
    logic [7:0] opc;
    case (op)
      2'b00:   opc = 8'h03;
      2'b01:   opc = 8'h02;
      2'b10:   opc = 8'hFF;
      2'b11:   opc = 8'h05;
      default: opc = 8'h00;
    endcase
    return {opc, (op[1] ? 16'h0000 : addr), ((op == 2'b01) ? wdata : 8'h00)};
  endfunction

  assign new_frame_s = build_frame(cmd_if.cmd_op, cmd_if.cmd_addr, cmd_if.cmd_wdata);

  // Next-state and next-output computation for the frame sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    frame_d     = frame_q;
    rx_d        = rx_q;
    op_d        = op_q;
    sck_d       = sck_q;
    nss_d       = nss_q;
    sdo_d       = sdo_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    cmd_ready_d = cmd_ready_q;
    busy_d      = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_if.cmd_valid && cmd_ready_q) begin
          state_d     = ST_LEAD;
          cnt_d       = DIV_LOAD;
          bit_cnt_d   = 6'd0;
          rx_d        = 8'h00;
          op_d        = cmd_if.cmd_op;
          sdo_d       = new_frame_s[31];
          frame_d     = {new_frame_s[30:0], 1'b0};
          sck_d       = 1'b0;
          nss_d       = 1'b0;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LEAD: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = ST_SHIFT;
          cnt_d   = DIV_LOAD;
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_SHIFT: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          cnt_d = DIV_LOAD;
          if (!sck_q) begin
            // Rising edge: responder data has been stable since the previous fall.
            sck_d     = 1'b1;
            rx_d      = {rx_q[6:0], SDI};
            bit_cnt_d = (bit_cnt_q == 6'd32) ? 6'd32 : (bit_cnt_q + 6'd1);
          end else begin
            sck_d = 1'b0;
            if (bit_cnt_q == 6'd32) begin
              sdo_d   = 1'b0;
              state_d = ST_TRAIL;
            end else begin
              sdo_d   = frame_q[31];
              frame_d = {frame_q[30:0], 1'b0};
            end
          end
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_TRAIL: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d     = ST_GAP;
          cnt_d       = GAP_LOAD;
          nss_d       = 1'b1;
          rsp_valid_d = 1'b1;
          // Only read and status return a byte; their op codes have equal bits.
          rsp_rdata_d = (op_q[1] == op_q[0]) ? rx_q : 8'h00;
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_GAP: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d     = ST_IDLE;
          cmd_ready_d = 1'b1;
          busy_d      = 1'b0;
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d     = ST_IDLE;
        sck_d       = 1'b0;
        nss_d       = 1'b1;
        sdo_d       = 1'b0;
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (bi_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      bit_cnt_q   <= 6'd0;
      frame_q     <= 32'h0000_0000;
      rx_q        <= 8'h00;
      op_q        <= 2'b00;
      sck_q       <= 1'b0;
      nss_q       <= 1'b1;
      sdo_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_q     <= frame_d;
      rx_q        <= rx_d;
      op_q        <= op_d;
      sck_q       <= sck_d;
      nss_q       <= nss_d;
      sdo_q       <= sdo_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign SCK              = sck_q;
  assign nSS              = nss_q;
  assign SDO              = sdo_q;
  assign cmd_if.cmd_ready = cmd_ready_q;
  assign cmd_if.busy      = busy_q;
  assign cmd_if.rsp_valid = rsp_valid_q;
  assign cmd_if.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_spi_flash_cmd_master.sv
// Directed bench for spi_flash_cmd_master: two instances (CLK_DIV=2/GAP_CYC=4
// and CLK_DIV=1/GAP_CYC=1), a mode-0 responder model and a scoreboard of
// expected frames/responses compared against what the bus monitor records.
module tb_spi_flash_cmd_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        bi_rst;
  logic        sel;
  logic        tb_valid;
  logic [1:0]  tb_op;
  logic [15:0] tb_addr;
  logic [7:0]  tb_wdata;
  logic        sdi;
  logic        sck_a, nss_a, sdo_a, sck_b, nss_b, sdo_b;

  spi_flash_cmd_master_if if_a ();
  spi_flash_cmd_master_if if_b ();

  assign if_a.cmd_valid = tb_valid & ~sel;
  assign if_a.cmd_op    = tb_op;
  assign if_a.cmd_addr  = tb_addr;
  assign if_a.cmd_wdata = tb_wdata;
  assign if_b.cmd_valid = tb_valid & sel;
  assign if_b.cmd_op    = tb_op;
  assign if_b.cmd_addr  = tb_addr;
  assign if_b.cmd_wdata = tb_wdata;

  spi_flash_cmd_master #(.CLK_DIV(2), .GAP_CYC(4)) dut_a (
    .clk(clk), .bi_rst(bi_rst), .cmd_if(if_a.slave),
    .SCK(sck_a), .nSS(nss_a), .SDO(sdo_a), .SDI(sdi));

  spi_flash_cmd_master #(.CLK_DIV(1), .GAP_CYC(1)) dut_b (
    .clk(clk), .bi_rst(bi_rst), .cmd_if(if_b.slave),
    .SCK(sck_b), .nSS(nss_b), .SDO(sdo_b), .SDI(sdi));

  // Observed (selected) instance
  wire       sck_m   = sel ? sck_b : sck_a;
  wire       nss_m   = sel ? nss_b : nss_a;
  wire       sdo_m   = sel ? sdo_b : sdo_a;
  wire       ready_m = sel ? if_b.cmd_ready : if_a.cmd_ready;
  wire       busy_m  = sel ? if_b.busy : if_a.busy;
  wire       rspv_m  = sel ? if_b.rsp_valid : if_a.rsp_valid;
  wire [7:0] rspd_m  = sel ? if_b.rsp_rdata : if_a.rsp_rdata;

  int tests = 0;
  int fails = 0;
  int cdiv;
  int gapc;

  // Monitor / responder state
  int          cyc = 0;
  logic        nss_prev = 1'b1;
  logic        sck_prev = 1'b0;
  logic [31:0] mon_frame = 32'h0;
  logic [31:0] sdi_word = 32'h0;
  int          mon_rises = 0, fall_idx = 0, low_cnt = 0, high_cnt = 0;
  bit          seen_frame = 1'b0;
  int          ready_err = 0;
  logic [31:0] frame_obs[$];
  logic [7:0]  rsp_obs[$];
  int          len_obs[$], gap_obs[$], acc_q[$], lat_obs[$];

  // Scoreboard of expected results
  logic [31:0] exp_frame_q[$];
  logic [7:0]  exp_rsp_q[$];

  // Bus monitor and mode-0 responder, sampling on the falling clk edge.
  initial begin
    sdi = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (tb_valid && ready_m && !bi_rst) acc_q.push_back(cyc);
      if (!nss_m && ready_m) ready_err++;
      if (!nss_prev && nss_m) begin
        frame_obs.push_back(mon_frame);
        len_obs.push_back(low_cnt);
        seen_frame = 1'b1;
        high_cnt = 0;
      end
      if (nss_prev && !nss_m) begin
        if (seen_frame) gap_obs.push_back(high_cnt);
        mon_frame = 32'h0; mon_rises = 0; fall_idx = 0; low_cnt = 0;
        sdi = sdi_word[31];
      end
      if (nss_m) high_cnt++; else low_cnt++;
      if (!nss_m && sck_m && !sck_prev) begin
        mon_frame = {mon_frame[30:0], sdo_m};
        mon_rises++;
      end
      if (!nss_m && !sck_m && sck_prev) begin
        fall_idx++;
        sdi = (fall_idx < 32) ? sdi_word[31-fall_idx] : 1'b0;
      end
      if (rspv_m) begin
        rsp_obs.push_back(rspd_m);
        lat_obs.push_back((acc_q.size() > 0) ? (cyc - acc_q.pop_front()) : -1);
      end
      nss_prev = nss_m;
      sck_prev = sck_m;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv)
      else begin
        fails++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready_m && n < 2000) begin tick(); n++; end
    if (n >= 2000) chk("ready_timeout", 32'(ready_m), 32'd1);
  endtask

  // Issue one command; optionally record the expected frame and response.
  task automatic issue(input logic [1:0] op, input logic [15:0] addr, input logic [7:0] wd,
                       input logic [7:0] sdi_b, input bit record,
                       input logic [31:0] ef, input logic [7:0] er);
    wait_ready();
    sdi_word = {24'h0, sdi_b};
    tb_op = op; tb_addr = addr; tb_wdata = wd; tb_valid = 1'b1;
    tick();
    tb_valid = 1'b0;
    if (record) begin
      exp_frame_q.push_back(ef);
      exp_rsp_q.push_back(er);
    end
  endtask

  task automatic wait_rsp(input int n);
    int k = 0;
    while (rsp_obs.size() < n && k < 5000) begin tick(); k++; end
    if (k >= 5000) chk("rsp_timeout", 32'(rsp_obs.size()), 32'(n));
  endtask

  task automatic check_one(input string tag);
    logic [31:0] f, ef;
    logic [7:0]  r, er;
    int          l, t;
    f  = (frame_obs.size() > 0) ? frame_obs.pop_front() : 32'hDEAD_BEEF;
    l  = (len_obs.size() > 0) ? len_obs.pop_front() : -1;
    r  = (rsp_obs.size() > 0) ? rsp_obs.pop_front() : 8'hxx;
    t  = (lat_obs.size() > 0) ? lat_obs.pop_front() : -1;
    ef = (exp_frame_q.size() > 0) ? exp_frame_q.pop_front() : 32'hxxxx_xxxx;
    er = (exp_rsp_q.size() > 0) ? exp_rsp_q.pop_front() : 8'hxx;
    chk({tag, "_frame"}, f, ef);
    chk({tag, "_nss_low"}, 32'(l), 32'(66 * cdiv));
    chk({tag, "_rdata"}, {24'h0, r}, {24'h0, er});
    chk({tag, "_latency"}, 32'(t), 32'(1 + 66 * cdiv));
  endtask

  initial begin
    sel = 1'b0; cdiv = 2; gapc = 4;
    bi_rst = 1'b1; tb_valid = 1'b0; tb_op = 2'b00; tb_addr = 16'h0; tb_wdata = 8'h0;
    repeat (3) tick();
    chk("rst_sck", 32'(sck_m), 32'd0);
    chk("rst_nss", 32'(nss_m), 32'd1);
    chk("rst_sdo", 32'(sdo_m), 32'd0);
    chk("rst_rspv", 32'(rspv_m), 32'd0);
    chk("rst_rdata", {24'h0, rspd_m}, 32'h0);
    chk("rst_ready", 32'(ready_m), 32'd1);
    chk("rst_busy", 32'(busy_m), 32'd0);
    bi_rst = 1'b0;
    tick();

    // Basic ops at CLK_DIV=2
    issue(2'b01, 16'h1234, 8'h5A, 8'hC3, 1'b1, 32'h0212_345A, 8'h00);
    chk("busy_in_frame", 32'(busy_m), 32'd1);
    wait_rsp(1); check_one("write");
    issue(2'b00, 16'h00FF, 8'h99, 8'hA5, 1'b1, 32'h0300_FF00, 8'hA5);
    wait_rsp(1); check_one("read");
    repeat (10) tick();
    chk("rdata_hold", {24'h0, rspd_m}, 32'h0000_00A5);
    chk("idle_ready", 32'(ready_m), 32'd1);
    issue(2'b10, 16'hBEEF, 8'h77, 8'h3C, 1'b1, 32'hFF00_0000, 8'h00);
    wait_rsp(1); check_one("flash_reset");
    issue(2'b11, 16'h1111, 8'h22, 8'h81, 1'b1, 32'h0500_0000, 8'h81);
    wait_rsp(1); check_one("status");

    // Back-to-back with cmd_valid held high
    wait_ready();
    gap_obs.delete();
    ready_err = 0;
    sdi_word = 32'h0000_005E;
    tb_op = 2'b00; tb_addr = 16'h4321; tb_wdata = 8'h00; tb_valid = 1'b1;
    tick();
    exp_frame_q.push_back(32'h0343_2100); exp_rsp_q.push_back(8'h5E);
    tb_op = 2'b11; tb_addr = 16'hAAAA; tb_wdata = 8'h11;
    wait_ready();
    tick();
    tb_valid = 1'b0;
    exp_frame_q.push_back(32'h0500_0000); exp_rsp_q.push_back(8'h5E);
    wait_rsp(2);
    check_one("b2b_first");
    check_one("b2b_second");
    chk("b2b_gap", 32'((gap_obs.size() > 0) ? gap_obs[0] : -1), 32'(gapc + 1));
    chk("ready_low_in_frame", 32'(ready_err), 32'd0);

    // Reset in the middle of a frame
    issue(2'b01, 16'hFFFF, 8'hFF, 8'h00, 1'b0, 32'h0, 8'h0);
    begin
      int k = 0;
      while (mon_rises < 10 && k < 1000) begin tick(); k++; end
      if (k >= 1000) chk("abort_wait", 32'(mon_rises), 32'd10);
    end
    chk("abort_nss_before", 32'(nss_m), 32'd0);
    bi_rst = 1'b1;
    tick();
    chk("abort_nss", 32'(nss_m), 32'd1);
    chk("abort_sck", 32'(sck_m), 32'd0);
    chk("abort_sdo", 32'(sdo_m), 32'd0);
    chk("abort_rspv", 32'(rspv_m), 32'd0);
    chk("abort_ready", 32'(ready_m), 32'd1);
    bi_rst = 1'b0;
    repeat (150) tick();
    chk("abort_no_rsp", 32'(rsp_obs.size()), 32'd0);
    frame_obs.delete(); len_obs.delete(); acc_q.delete(); lat_obs.delete();
    issue(2'b11, 16'h0000, 8'h00, 8'h81, 1'b1, 32'h0500_0000, 8'h81);
    wait_rsp(1); check_one("after_abort");

    // Fastest configuration: CLK_DIV=1, GAP_CYC=1
    repeat (10) tick();
    bi_rst = 1'b1; tick(); sel = 1'b1; cdiv = 1; gapc = 1; tick();
    bi_rst = 1'b0; tick();
    frame_obs.delete(); len_obs.delete(); acc_q.delete(); lat_obs.delete(); rsp_obs.delete();
    issue(2'b01, 16'h1234, 8'h5A, 8'h00, 1'b1, 32'h0212_345A, 8'h00);
    wait_rsp(1); check_one("fast_write");
    issue(2'b00, 16'h00FF, 8'h00, 8'hA5, 1'b1, 32'h0300_FF00, 8'hA5);
    wait_rsp(1); check_one("fast_read");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
